uart_program_loader: RTL

//   Writer side of the instruction-memory path: takes a byte stream from the UART receiver, packs bytes

---
 rtl/uart_program_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_program_loader.sv
// uart_program_loader: packs a UART byte stream (LEN_HI, LEN_LO, N big-endian words) into instruction RAM.
// Holds the CPU in reset while loading. Define CHECKSUM_EN to require a trailing XOR checksum byte.

module uart_program_loader #(
   parameter int unsigned ADDR_W      = 14,
   parameter int unsigned TIMEOUT_CYC = 2000000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              prog_wen,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [31:0]       prog_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [15:0]       words_loaded
);

   localparam int unsigned      MAX_WORDS = 2 ** ADDR_W;
   localparam int unsigned      TMO_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_WRITE,
      S_CHK,
      S_DONE
   } state_t;

   // Where the frame goes once the last word (or an empty count) is through.
`ifdef CHECKSUM_EN
   localparam state_t TAIL    = S_CHK;
   localparam logic   TAIL_RX = 1'b1;
`else
   localparam state_t TAIL    = S_DONE;
   localparam logic   TAIL_RX = 1'b0;
`endif

   state_t           state;
   logic [15:0]      count;
   logic [1:0]       byte_idx;
   logic [TMO_W-1:0] tmo_cnt;
`ifdef CHECKSUM_EN
   logic [7:0]       csum;
`endif

   logic        accept;
   logic [15:0] len_full;
   logic [15:0] words_next;

   assign accept     = rx_valid & rx_ready;
   assign len_full   = {count[15:8], rx_data};
   assign words_next = words_loaded + 16'd1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         count        <= '0;
         byte_idx     <= '0;
         tmo_cnt      <= '0;
         rx_ready     <= 1'b0;
         prog_wen     <= 1'b0;
         prog_addr    <= '0;
         prog_wdata   <= '0;
         cpu_hold     <= 1'b0;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
         words_loaded <= '0;
`ifdef CHECKSUM_EN
         csum         <= '0;
`endif
      end else begin
         prog_wen  <= 1'b0;
         load_done <= 1'b0;

         // Inter-byte timeout; only runs while a byte is expected and never coincides with an accept.
         if (rx_ready) begin
            if (accept) begin
               tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
               state     <= S_DONE;
               rx_ready  <= 1'b0;
               load_err  <= 1'b1;
               load_done <= 1'b1;
               tmo_cnt   <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
         end

`ifdef CHECKSUM_EN
         if (accept) csum <= csum ^ rx_data;
`endif

         case (state)
            S_IDLE: begin
               if (load_start) begin
                  state        <= S_LEN_HI;
                  cpu_hold     <= 1'b1;
                  load_err     <= 1'b0;
                  words_loaded <= '0;
                  prog_addr    <= '0;
                  rx_ready     <= 1'b1;
                  tmo_cnt      <= '0;
                  byte_idx     <= '0;
`ifdef CHECKSUM_EN
                  csum         <= '0;
`endif
               end
            end
            S_LEN_HI: begin
               if (accept) begin
                  count[15:8] <= rx_data;
                  state       <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (accept) begin
                  count[7:0] <= rx_data;
                  if (len_full == 16'd0) begin
                     state     <= TAIL;
                     rx_ready  <= TAIL_RX;
                     load_done <= ~TAIL_RX;
                  end else if (32'(len_full) > MAX_WORDS) begin
                     state     <= S_DONE;
                     rx_ready  <= 1'b0;
                     load_err  <= 1'b1;
                     load_done <= 1'b1;
                  end else begin
                     state    <= S_DATA;
                     byte_idx <= '0;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  case (byte_idx)
                     2'd0:    prog_wdata[31:24] <= rx_data;
                     2'd1:    prog_wdata[23:16] <= rx_data;
                     2'd2:    prog_wdata[15:8]  <= rx_data;
                     default: prog_wdata[7:0]   <= rx_data;
                  endcase
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     state    <= S_WRITE;
                     prog_wen <= 1'b1;
                     rx_ready <= 1'b0;
                  end
               end
            end
            S_WRITE: begin
               prog_addr    <= prog_addr + ADDR_W'(1);
               words_loaded <= words_next;
               if (words_next == count) begin
                  state     <= TAIL;
                  rx_ready  <= TAIL_RX;
                  load_done <= ~TAIL_RX;
               end else begin
                  state    <= S_DATA;
                  rx_ready <= 1'b1;
               end
            end
`ifdef CHECKSUM_EN
            S_CHK: begin
               if (accept) begin
                  if (rx_data != csum) load_err <= 1'b1;
                  state     <= S_DONE;
                  rx_ready  <= 1'b0;
                  load_done <= 1'b1;
               end
            end
`endif
            S_DONE: begin
               cpu_hold <= 1'b0;
               state    <= S_IDLE;
            end
            default: begin
               state    <= S_IDLE;
               rx_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
